// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter with bounded locked bursts for a single-port data memory
//
// Purpose: shares one single-port memory (async read, write at clk edge) between
// port 0 (CPU load/store) and port 1 (loader/debug/DMA). Grants are combinational
// so an access completes in the cycle it is granted; read data returns registered
// one cycle later.
//
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   req0/we0/lock0/addr0/wdata0    port 0 request, write enable, lock, address, write data
//   gnt0/rvalid0/rdata0            port 0 grant (comb), read valid, registered read data
//   req1/we1/lock1/addr1/wdata1    port 1 request side
//   gnt1/rvalid1/rdata1            port 1 response side
//   mem_addr/mem_wdata/mem_we      memory request side
//   mem_rdata                      memory async read data
module mem_arbiter #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 1024,
  parameter int ADD_SIZE  = $clog2(DEPTH),
  parameter int MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                we0,
  input  logic                lock0,
  input  logic [ADD_SIZE-1:0] addr0,
  input  logic [WIDTH-1:0]    wdata0,
  output logic                gnt0,
  output logic                rvalid0,
  output logic [WIDTH-1:0]    rdata0,
  input  logic                req1,
  input  logic                we1,
  input  logic                lock1,
  input  logic [ADD_SIZE-1:0] addr1,
  input  logic [WIDTH-1:0]    wdata1,
  output logic                gnt1,
  output logic                rvalid1,
  output logic [WIDTH-1:0]    rdata1,
  output logic [ADD_SIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  output logic                mem_we,
  input  logic [WIDTH-1:0]    mem_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  logic [1:0]    state, state_n;
  logic          rr_ptr;
  logic [CW-1:0] burst_cnt, burst_cnt_n;
  logic [CW-1:0] cnt_base, cnt_inc;
  logic          gnt_lock;

  // Grants are forced low during reset so the memory cannot be written.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      case (state)
        LOCK0: begin
          if (req0)      gnt0 = 1'b1;
          else if (req1) gnt1 = 1'b1;
        end
        LOCK1: begin
          if (req1)      gnt1 = 1'b1;
          else if (req0) gnt0 = 1'b1;
        end
        default: begin
          if (req0 && req1) begin
            gnt0 = ~rr_ptr;
            gnt1 = rr_ptr;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
      endcase
    end
  end

  always_comb begin
    mem_addr  = gnt1 ? addr1 : addr0;
    mem_wdata = gnt1 ? wdata1 : wdata0;
    mem_we    = (gnt0 & we0) | (gnt1 & we1);
  end

  // A grant to a port that does not already own the lock starts a fresh burst
  // count; only the current owner continues accumulating.
  always_comb begin
    state_n     = IDLE;
    burst_cnt_n = '0;
    gnt_lock    = gnt1 ? lock1 : lock0;
    cnt_base    = ((state == LOCK0 && gnt0) || (state == LOCK1 && gnt1)) ? burst_cnt : '0;
    cnt_inc     = cnt_base + 1'b1;
    if ((gnt0 || gnt1) && gnt_lock && (cnt_inc < MAX_CNT)) begin
      state_n     = gnt1 ? LOCK1 : LOCK0;
      burst_cnt_n = cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      burst_cnt <= '0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      state     <= state_n;
      burst_cnt <= burst_cnt_n;
      // Priority passes to the port that was not just served.
      if (gnt0 || gnt1) rr_ptr <= gnt0;
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 && !we0) rdata0 <= mem_rdata;
      if (gnt1 && !we1) rdata1 <= mem_rdata;
    end
  end

endmodule
